// File: rtl/text_grid_pkg.sv
// text_grid_pkg: video stream layout shared by the text grid pipeline.
package text_grid_pkg;
  localparam int STREAM_W = 26;
  localparam int ACTIVE_BIT = 0;
  localparam int VS_BIT = 1;
  localparam int HS_BIT = 2;
  localparam int Y_LSB = 3;
  localparam int Y_MSB = 12;
  localparam int X_LSB = 13;
  localparam int X_MSB = 22;
  localparam int RGB_LSB = 23;
  localparam int RGB_MSB = 25;
  localparam int XY_W = 10;
  typedef struct packed {
    logic [RGB_MSB-RGB_LSB:0] rgb;
    logic [X_MSB-X_LSB:0]     x;
    logic [Y_MSB-Y_LSB:0]     y;
    logic                     hs;
    logic                     vs;
    logic                     active;
  } stream_t;
endpackage

// File: rtl/text_blink_timer.sv
// text_blink_timer: VS rising-edge detect and cursor blink phase.
// Blink counter only exists when TEXT_GRID_CURSOR_BLINK_EN is defined.
module text_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic px_clk,
  input  logic reset,
  input  logic vs,
  output logic vs_rise,
  output logic blink_phase
);
  logic vs_q;
  always_ff @(posedge px_clk or posedge reset)
    if (reset) vs_q <= 1'b0;
    else vs_q <= vs;
  assign vs_rise = vs & ~vs_q;
`ifdef TEXT_GRID_CURSOR_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] cnt;
  logic phase;
  always_ff @(posedge px_clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      phase <= 1'b1;
    end else if (vs_rise) begin
      cnt <= (cnt == BW'(BLINK_FRAMES-1)) ? '0 : cnt + 1'b1;
      phase <= (cnt == BW'(BLINK_FRAMES-1)) ? ~phase : phase;
    end
  assign blink_phase = phase;
`else
  assign blink_phase = 1'b1;
`endif
endmodule

// File: rtl/text_grid_pipe.sv
// text_grid_pipe: maps a pixel stream onto a scrolled text grid (VRAM address, glyph coords, cursor).
// Optional cursor blink via macro TEXT_GRID_CURSOR_BLINK_EN (steady cursor when undefined).
module text_grid_pipe
  import text_grid_pkg::*;
#(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          px_clk,
  input  logic                          reset,
  input  logic [STREAM_W-1:0]           RGBStr_i,
  output logic [STREAM_W-1:0]           RGBStr_o,
  input  logic [$clog2(ROWS)-1:0]       row_offset,
  input  logic [$clog2(COLS)-1:0]       cursor_col,
  input  logic [$clog2(ROWS)-1:0]       cursor_row,
  output logic [$clog2(COLS*ROWS)-1:0]  addr_vram,
  output logic [$clog2(GLYPH_W)-1:0]    glyph_x,
  output logic [$clog2(GLYPH_H)-1:0]    glyph_y,
  output logic [XY_W-1:0]               pos_x,
  output logic [XY_W-1:0]               pos_y,
  output logic                          in_text,
  output logic                          cursor_on
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(COLS*ROWS);
  localparam int GXW = $clog2(GLYPH_W);
  localparam int GYW = $clog2(GLYPH_H);
  localparam int XCW = XY_W - GXW;
  localparam int YRW = XY_W - GYW;
  localparam logic [XCW-1:0] COLS_X = XCW'(COLS);
  localparam logic [YRW-1:0] ROWS_Y = YRW'(ROWS);
  localparam logic [RW:0] ROWS_W = (RW+1)'(ROWS);
  stream_t s1, s2, s3;
  logic [RW-1:0] row_off_q;
  logic vs_rise, blink_phase;
  logic [XCW-1:0] col_f;
  logic [YRW-1:0] row_f;
  logic [RW:0] row_sum;
  logic [RW-1:0] row_scr;
  logic hit, cur_hit;
  logic t_in, t_cur;
  logic [CW-1:0] t_col;
  logic [RW-1:0] t_row;
  logic [GXW-1:0] t_gx;
  logic [GYW-1:0] t_gy;
  logic [XY_W-1:0] t_px, t_py;
  text_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .px_clk     (px_clk),
    .reset      (reset),
    .vs         (RGBStr_i[VS_BIT]),
    .vs_rise    (vs_rise),
    .blink_phase(blink_phase)
  );
  always_comb begin
    col_f = s1.x[XY_W-1:GXW];
    row_f = s1.y[XY_W-1:GYW];
    hit = s1.active && (col_f < COLS_X) && (row_f < ROWS_Y);
    row_sum = {1'b0, row_f[RW-1:0]} + {1'b0, row_off_q};
    row_scr = (row_sum >= ROWS_W) ? RW'(row_sum - ROWS_W) : row_sum[RW-1:0];
    cur_hit = hit && blink_phase && (col_f == XCW'(cursor_col)) && (row_f == YRW'(cursor_row));
  end
  always_ff @(posedge px_clk or posedge reset)
    if (reset) begin
      row_off_q <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      RGBStr_o <= '0;
      {t_in, t_cur, t_col, t_row, t_gx, t_gy, t_px, t_py} <= '0;
      {in_text, cursor_on, addr_vram, glyph_x, glyph_y, pos_x, pos_y} <= '0;
    end else begin
      // out-of-range scroll requests keep the previous offset
      if (vs_rise && ({1'b0, row_offset} < ROWS_W)) row_off_q <= row_offset;
      s1 <= RGBStr_i;
      s2 <= s1;
      s3 <= s2;
      RGBStr_o <= s3;
      t_in <= hit;
      t_cur <= cur_hit;
      t_col <= col_f[CW-1:0];
      t_row <= row_scr;
      t_gx <= s1.x[GXW-1:0];
      t_gy <= s1.y[GYW-1:0];
      t_px <= {s1.x[XY_W-1:GXW], {GXW{1'b0}}};
      t_py <= {s1.y[XY_W-1:GYW], {GYW{1'b0}}};
      in_text <= t_in;
      cursor_on <= t_cur;
      addr_vram <= t_in ? AW'(t_row) * AW'(COLS) + AW'(t_col) : '0;
      glyph_x <= t_gx;
      glyph_y <= t_gy;
      pos_x <= t_px;
      pos_y <= t_py;
    end
endmodule
